// File: rtl/pcr_snap_arb.sv
// pcr_snap_arb: round-robin arbiter that serves PCR snapshot requests from
//   several restamp engines with a coherent base/ext capture of the shared
//   PCR counter, an optional latency compensation, and a requester id tag.
// Latency: req in cycle N -> snap_vld in N+3 (PCR_SNAP_ADJ_EN) or N+2 (without).
// Backpressure: none downstream; requests arriving while busy wait in pend,
//   with at most one outstanding snapshot per requester.
// Optional feature macro: PCR_SNAP_ADJ_EN (adds ADJ state + ADJ_EXT adder).
// Ports:
//   clk_main_a, rst_gen (async, active-low)
//   req[NUM_REQ]              per-requester one-cycle request pulse
//   pcr_base_cnt[33], pcr_ext_cnt[9]  live PCR counter
//   snap_vld, snap_id, snap_base, snap_ext   result strobe and held result
//   busy                      FSM outside IDLE
module pcr_snap_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int ADJ_EXT = 3
) (
  input  logic               clk_main_a,
  input  logic               rst_gen,
  input  logic [NUM_REQ-1:0] req,
  input  logic [32:0]        pcr_base_cnt,
  input  logic [8:0]         pcr_ext_cnt,
  output logic               snap_vld,
  output logic [ID_W-1:0]    snap_id,
  output logic [32:0]        snap_base,
  output logic [8:0]         snap_ext,
  output logic               busy
);

  if (NUM_REQ < 2 || NUM_REQ > 16 || NUM_REQ > (1 << ID_W) ||
      ADJ_EXT < 0 || ADJ_EXT > 299) begin : g_bad_cfg
    $error("pcr_snap_arb: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, ADJ = 2'd1, DONE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] pend_q, pend_d;
  logic [ID_W-1:0]    last_gnt_q, last_gnt_d;
  logic [ID_W-1:0]    snap_id_q, snap_id_d;
  logic [32:0]        snap_base_q, snap_base_d;
  logic [8:0]         snap_ext_q, snap_ext_d;

`ifdef PCR_SNAP_ADJ_EN
  localparam logic [9:0] ADJ_C = 10'(ADJ_EXT);
  logic [32:0]     raw_base_q, raw_base_d;
  logic [8:0]      raw_ext_q, raw_ext_d;
  logic [ID_W-1:0] gnt_id_q, gnt_id_d;
  logic [9:0]      sum;
`endif

  // Round-robin search: the first pending index above last_gnt wins; if none,
  // the first pending index at or below it (wrap-around).
  logic               hi_vld, lo_vld, win_vld;
  logic [ID_W-1:0]    hi_id, lo_id, win_id;

  always_comb begin
    hi_vld = 1'b0;
    lo_vld = 1'b0;
    hi_id  = '0;
    lo_id  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pend_q[i]) begin
        if (i > int'(last_gnt_q)) begin
          if (!hi_vld) begin
            hi_vld = 1'b1;
            hi_id  = ID_W'(i);
          end
        end else if (!lo_vld) begin
          lo_vld = 1'b1;
          lo_id  = ID_W'(i);
        end
      end
    end
    win_vld = hi_vld | lo_vld;
    win_id  = hi_vld ? hi_id : lo_id;
  end

  logic               grant;
  logic [NUM_REQ-1:0] gnt_oh;

  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    snap_id_d   = snap_id_q;
    snap_base_d = snap_base_q;
    snap_ext_d  = snap_ext_q;
    grant       = 1'b0;
`ifdef PCR_SNAP_ADJ_EN
    raw_base_d  = raw_base_q;
    raw_ext_d   = raw_ext_q;
    gnt_id_d    = gnt_id_q;
    sum         = '0;
`endif
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          grant      = 1'b1;
          last_gnt_d = win_id;
`ifdef PCR_SNAP_ADJ_EN
          raw_base_d = pcr_base_cnt;
          raw_ext_d  = pcr_ext_cnt;
          gnt_id_d   = win_id;
          state_d    = ADJ;
`else
          // No compensation: the capture goes straight to the result regs.
          snap_id_d   = win_id;
          snap_base_d = pcr_base_cnt;
          snap_ext_d  = pcr_ext_cnt;
          state_d     = DONE;
`endif
        end
      end
`ifdef PCR_SNAP_ADJ_EN
      ADJ: begin
        // 10 bits hold any 9-bit ext (even illegal >299) plus up to 299.
        sum       = {1'b0, raw_ext_q} + ADJ_C;
        snap_id_d = gnt_id_q;
        if (sum >= 10'd300) begin
          snap_ext_d  = 9'(sum - 10'd300);
          snap_base_d = raw_base_q + 33'd1;
        end else begin
          snap_ext_d  = sum[8:0];
          snap_base_d = raw_base_q;
        end
        state_d = DONE;
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    for (int i = 0; i < NUM_REQ; i++) begin
      gnt_oh[i] = grant && (win_id == ID_W'(i));
    end
    // A request in the grant cycle re-queues: set wins over clear.
    pend_d = (pend_q & ~gnt_oh) | req;
  end

  always_ff @(posedge clk_main_a or negedge rst_gen) begin
    if (!rst_gen) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      last_gnt_q  <= ID_W'(NUM_REQ - 1);
      snap_id_q   <= '0;
      snap_base_q <= '0;
      snap_ext_q  <= '0;
`ifdef PCR_SNAP_ADJ_EN
      raw_base_q  <= '0;
      raw_ext_q   <= '0;
      gnt_id_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      last_gnt_q  <= last_gnt_d;
      snap_id_q   <= snap_id_d;
      snap_base_q <= snap_base_d;
      snap_ext_q  <= snap_ext_d;
`ifdef PCR_SNAP_ADJ_EN
      raw_base_q  <= raw_base_d;
      raw_ext_q   <= raw_ext_d;
      gnt_id_q    <= gnt_id_d;
`endif
    end
  end

  assign snap_vld  = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign snap_id   = snap_id_q;
  assign snap_base = snap_base_q;
  assign snap_ext  = snap_ext_q;

endmodule

// File: tb/tb_pcr_snap_arb.sv
// tb_pcr_snap_arb: directed bench for pcr_snap_arb with a scoreboard queue.
// Expected snapshots (id, value, strobe cycle) are queued when requests are
// driven and popped when snap_vld is seen; works with or without PCR_SNAP_ADJ_EN.
module tb_pcr_snap_arb;

  localparam int ADJ = 3;
`ifdef PCR_SNAP_ADJ_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk_main_a;
  logic        rst_gen;
  logic [3:0]  req;
  logic [32:0] pcr_base_cnt;
  logic [8:0]  pcr_ext_cnt;
  logic        snap_vld;
  logic [1:0]  snap_id;
  logic [32:0] snap_base;
  logic [8:0]  snap_ext;
  logic        busy;

  pcr_snap_arb #(.NUM_REQ(4), .ID_W(2), .ADJ_EXT(ADJ)) dut (
    .clk_main_a   (clk_main_a),
    .rst_gen      (rst_gen),
    .req          (req),
    .pcr_base_cnt (pcr_base_cnt),
    .pcr_ext_cnt  (pcr_ext_cnt),
    .snap_vld     (snap_vld),
    .snap_id      (snap_id),
    .snap_base    (snap_base),
    .snap_ext     (snap_ext),
    .busy         (busy)
  );

  initial clk_main_a = 1'b0;
  always #5 clk_main_a = ~clk_main_a;

  typedef struct {
    logic [1:0]  id;
    logic [32:0] base;
    logic [8:0]  ext;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = -1;
  bit          ramp     = 1'b0;
  logic [32:0] fix_base = '0;
  logic [8:0]  fix_ext  = '0;

  function automatic logic [32:0] cnt_base(int c);
    return ramp ? (33'h1_FFFF_FFF0 + 33'(c)) : fix_base;
  endfunction

  function automatic logic [8:0] cnt_ext(int c);
    return ramp ? 9'((c * 37 + 290) % 300) : fix_ext;
  endfunction

  function automatic logic [41:0] model_adj(logic [32:0] b, logic [8:0] x);
    int s;
    s = int'(x) + ADJ;
`ifdef PCR_SNAP_ADJ_EN
    if (s >= 300) return {b + 33'd1, 9'(s - 300)};
    return {b, 9'(s)};
`else
    return {b, x};
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  // Expected result for a grant made in cycle g.
  task automatic push_exp(input logic [1:0] id, input int g);
    exp_t e;
    e.id = id;
    {e.base, e.ext} = model_adj(cnt_base(g), cnt_ext(g));
    e.cyc = g + LAT - 1;
    sb.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    if (snap_vld === 1'b1) begin
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_vld observed=1 expected=0 cycle=%0d", cyc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("snap_cycle", 64'(cyc), 64'(e.cyc));
        chk("snap_id", 64'(snap_id), 64'(e.id));
        chk("snap_base", 64'(snap_base), 64'(e.base));
        chk("snap_ext", 64'(snap_ext), 64'(e.ext));
      end
    end
  endtask

  // One cycle: at the falling edge sample outputs of this cycle, then drive it.
  task automatic step(input logic [3:0] r);
    @(negedge clk_main_a);
    cyc++;
    monitor();
    req          = r;
    pcr_base_cnt = cnt_base(cyc);
    pcr_ext_cnt  = cnt_ext(cyc);
  endtask

  task automatic do_reset();
    rst_gen = 1'b0;
    repeat (3) step(4'b0000);
    rst_gen = 1'b1;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_vld"},  64'(snap_vld),  64'd0);
    chk({tag, "_id"},   64'(snap_id),   64'd0);
    chk({tag, "_base"}, 64'(snap_base), 64'd0);
    chk({tag, "_ext"},  64'(snap_ext),  64'd0);
    chk({tag, "_busy"}, 64'(busy),      64'd0);
  endtask

  initial begin
    int c0;
    int c1;
    rst_gen      = 1'b0;
    req          = '0;
    pcr_base_cnt = '0;
    pcr_ext_cnt  = '0;

    // Reset state
    do_reset();
    chk_zero_outputs("rst");

    // Single request, latency and busy window
    ramp = 1'b0; fix_base = 33'h0_0000_1000; fix_ext = 9'd100;
    step(4'b0100); c0 = cyc;
    push_exp(2'd2, c0 + 1);
    for (int k = 1; k <= 6; k++) begin
      step(4'b0000);
      chk("busy", 64'(busy), 64'((cyc >= c0 + 2 && cyc <= c0 + LAT) ? 1 : 0));
    end
    chk("drain_single", 64'(sb.size()), 64'd0);

    // Carry into base and base wrap
    fix_base = 33'h1_FFFF_FFFF; fix_ext = 9'd298;
    step(4'b0001); c0 = cyc;
    push_exp(2'd0, c0 + 1);
    repeat (6) step(4'b0000);
    chk("drain_carry", 64'(sb.size()), 64'd0);

    // Simultaneous requests, counter moving every cycle
    do_reset();
    ramp = 1'b1;
    step(4'b1111); c0 = cyc;
    for (int k = 0; k < 4; k++) push_exp(2'(k), c0 + 1 + k * LAT);
    repeat (4 * LAT + 4) step(4'b0000);
    chk("drain_simul", 64'(sb.size()), 64'd0);

    // Fairness: req[0] held, req[3] pulsed once
    do_reset();
    step(4'b1001); c0 = cyc;
    push_exp(2'd0, c0 + 1);
    push_exp(2'd3, c0 + 1 + LAT);
    push_exp(2'd0, c0 + 1 + 2 * LAT);
    push_exp(2'd0, c0 + 1 + 3 * LAT);
    while (cyc < c0 + 1 + 2 * LAT) step(4'b0001);
    repeat (3 * LAT + 4) step(4'b0000);
    chk("drain_fair", 64'(sb.size()), 64'd0);

    // Set wins: req[1] again in the cycle its pending bit is granted
    do_reset();
    ramp = 1'b0; fix_base = 33'h0_1234_5678; fix_ext = 9'd299;
    step(4'b0010); c0 = cyc;
    step(4'b0010);
    push_exp(2'd1, c0 + 1);
    push_exp(2'd1, c0 + 1 + LAT);
    repeat (2 * LAT + 4) step(4'b0000);
    chk("drain_setwin", 64'(sb.size()), 64'd0);

    // Reset mid-sequence with pend=0110
    do_reset();
    fix_base = 33'h0_0000_1000; fix_ext = 9'd100;
    step(4'b1000); c0 = cyc;
    push_exp(2'd3, c0 + 1);
    repeat (LAT + 2) step(4'b0000);
    step(4'b0111); c0 = cyc;
    step(4'b0000);
`ifndef PCR_SNAP_ADJ_EN
    push_exp(2'd0, c0 + 1);
`endif
    step(4'b0000);
    rst_gen = 1'b0;
    #1;
    chk_zero_outputs("midrst");
    repeat (2) step(4'b0000);
    rst_gen = 1'b1;
    repeat (10) step(4'b0000);
    chk("post_rst_idle", 64'(busy), 64'd0);
    step(4'b1000); c1 = cyc;
    push_exp(2'd3, c1 + 1);
    repeat (LAT + 4) step(4'b0000);
    chk("drain_midrst", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pcr_snap_arb.md
# pcr_snap_arb

Round-robin arbiter and sequencer that shares the free-running PCR counter (33-bit base, 9-bit extension counting 0..299 at 27 MHz) among several TS-channel PCR restamp engines. Each engine pulses a request. The block grants one requester at a time and captures a coherent base/ext snapshot. It optionally adds a fixed pipeline-latency compensation in 27 MHz ticks, then returns the result tagged with the requester id. It sits between the PCR counter and the per-channel PCR correction logic in the clk_main_a domain.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- ID_W, 2, width of snap_id; NUM_REQ <= 2**ID_W
- ADJ_EXT, 3, compensation added to the snapshot in 27 MHz ticks (0..299)
- clk_main_a  input  1  system clock; all logic on the rising edge
- rst_gen  input  1  asynchronous, active-low reset
- req  input  NUM_REQ  per-requester snapshot request; one-cycle pulse per snapshot
- pcr_base_cnt  input  33  live PCR base counter
- pcr_ext_cnt  input  9  live PCR extension counter (0..299)
- snap_vld  output  1  one-cycle strobe: snap_id/snap_base/snap_ext valid
- snap_id  output  ID_W  index of the requester served
- snap_base  output  33  snapshot base, adjusted
- snap_ext  output  9  snapshot extension, adjusted (0..299)
- busy  output  1  high whenever the FSM is not in IDLE

## Operation
- Pending register pend[NUM_REQ-1:0]: req[i]=1 sets pend[i]; a grant clears it. When a grant clears pend[i] in the same cycle req[i] is high, set wins, and one further snapshot is queued. A level-held req therefore produces back-to-back snapshots.
- Round-robin pointer last_gnt: the search starts at last_gnt+1 and wraps modulo NUM_REQ. The first set pend bit wins, and last_gnt updates to the winner.
- FSM states are IDLE, ADJ and DONE.
  - IDLE: if pend is nonzero, the edge selects the winner, clears its pend bit, and latches raw_base/raw_ext from the inputs and the id. Next state is ADJ, or DONE if adjustment is compiled out. Otherwise the FSM stays in IDLE.
  - ADJ: computes sum = raw_ext + ADJ_EXT at 10-bit width.
    - If sum >= 300: snap_ext = sum-300 and snap_base = raw_base+1 modulo 2^33. 2^33-1 wraps to 0.
    - Otherwise snap_ext = sum and snap_base = raw_base.
    - Next state is DONE.
  - DONE: snap_vld=1 for exactly this cycle. Next state is IDLE.
- snap_id, snap_base and snap_ext are registered. They hold their value until the next DONE.
- The snapshot value is the counter input present in the IDLE cycle in which the grant is made.
- If raw_ext > 299 (illegal input), the value passes through unchanged apart from the adjustment arithmetic. No error is flagged.
- Requests arriving while busy accumulate in pend. None are lost, and each requester holds at most one outstanding snapshot.

## Timing
- Reset (rst_gen=0, asynchronous):
  - state=IDLE, pend=0, last_gnt=NUM_REQ-1 (requester 0 has first priority).
  - snap_vld=0, snap_id=0, snap_base=0, snap_ext=0, busy=0.
- Reset asserted mid-sequence aborts the sequence: no snap_vld is produced and all pending requests are discarded.
- Latency with an idle FSM: req pulse in cycle N, then pend is set in N+1 and the grant and capture happen at the end of N+1.
  - ADJ is in N+2 and snap_vld is high in N+3.
  - Without the macro, snap_vld is high in N+2.
- Throughput: one snapshot per 3 cycles, or 2 without the macro. IDLE is always visited for one cycle between grants.
- busy is high in ADJ and DONE.

## Configuration
- PCR_SNAP_ADJ_EN defined: the ADJ state and adder are included, and the ADJ_EXT compensation with carry into base is applied.
- PCR_SNAP_ADJ_EN undefined: ADJ is removed and IDLE goes directly to DONE. snap_base/snap_ext equal the raw captured values, and ADJ_EXT is ignored.

## Test plan
- Single request, macro on, ADJ_EXT=3: base=0x0_0000_1000, ext=100 held constant; req[2] pulses in cycle 0. Required: snap_vld in cycle 3 with snap_id=2, snap_base=0x0_0000_1000, snap_ext=103.
- Carry and wrap: base=2^33-1, ext=298, ADJ_EXT=3. Required: snap_base=0, snap_ext=1.
- Simultaneous requests: req=4'b1111 in one cycle after reset. Required: four snap_vld strobes 3 cycles apart, ids 0,1,2,3.
- Fairness: req[0] held high and req[3] pulsed once. Required: the served ids alternate 0,3,0,0,...; requester 3 is served within 2 grants.
- Set-wins collision: req[1] pulses in the exact cycle its pending bit is granted. Required: two snapshots for id 1.
- Reset mid-op: rst_gen low during ADJ with pend=4'b0110. Required: outputs 0 and no snap_vld after release until a new req. With the macro off, the same single-request test gives snap_vld in cycle 2 with snap_ext=100.
